spi_frame_master: RTL and testbench

SPI mode-0 master that shifts one fixed-length command frame out on MOSI while capturing an equal-length response on MISO. It is the initiator for the board's 88-bit SPI command frame, which carries PWM duty, stepper target and control bytes. The block lets one FPGA configure another smart-home node, or loop back into our own SPI slave, without an MCU. It sits between a local command source, driving `start` and `tx_frame`, and the four SPI pins.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_frame_master_if.sv | 26 ++
 rtl/spi_frame_master_sync2.sv | 21 ++
 rtl/spi_frame_master.sv | 146 ++++++++++++++
 tb/tb_spi_frame_master.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared defaults and FSM state encoding for the SPI command-frame master.
package spi_pkg;

  localparam int FRAME_BITS_DEF = 88;
  localparam int CLK_DIV_DEF    = 25;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_m_state_t;

endpackage

// File: rtl/spi_frame_master_if.sv
// Command-side handshake plus the four SPI pins of one frame master.
interface spi_frame_master_if #(
  parameter int FRAME_BITS = spi_pkg::FRAME_BITS_DEF
) ();

  logic                  start;
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_frame;
  logic                  SCK;
  logic                  MOSI;
  logic                  MISO;
  logic                  SSEL;

  modport master (
    input  start, tx_frame, MISO,
    output busy, done, rx_frame, SCK, MOSI, SSEL
  );

  modport slave (
    output start, tx_frame, MISO,
    input  busy, done, rx_frame, SCK, MOSI, SSEL
  );

endinterface

// File: rtl/spi_frame_master_sync2.sv
// Two-flop synchronizer for the asynchronous MISO pin; adds 2 cycles of latency.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master: one FRAME_BITS frame per start, MSB first, full duplex.
// Frame takes CLK_DIV*(2*FRAME_BITS+1) cycles plus a CLK_DIV gap; start ignored while busy.
module spi_frame_master #(
  parameter int FRAME_BITS = spi_pkg::FRAME_BITS_DEF,
  parameter int CLK_DIV    = spi_pkg::CLK_DIV_DEF
) (
  input  logic                clk50M,
  input  logic                rst_n,
  spi_frame_master_if.master  bus
);

  import spi_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  spi_m_state_t          state, state_nxt;
  logic [DW-1:0]         div_cnt;
  logic                  div_last;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-2:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic [FRAME_BITS-1:0] rx_frame_q;
  logic                  sck_q, mosi_q, ssel_q, done_q;
  logic                  sck_nxt, mosi_nxt, ssel_nxt, done_nxt;
  logic                  load, tx_shift, rx_shift, rx_load;
  logic                  miso_s;

  sync2 u_miso_sync (
    .clk   (clk50M),
    .rst_n (rst_n),
    .d     (bus.MISO),
    .q     (miso_s)
  );

  assign div_last = (div_cnt == DIV_LAST);

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pin levels are computed one cycle ahead so every SPI output leaves a flop.
  always_comb begin
    state_nxt = state;
    sck_nxt   = sck_q;
    mosi_nxt  = mosi_q;
    ssel_nxt  = ssel_q;
    done_nxt  = 1'b0;
    load      = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;
    rx_load   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          ssel_nxt  = 1'b0;
          sck_nxt   = 1'b0;
          mosi_nxt  = bus.tx_frame[FRAME_BITS-1];
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          sck_nxt   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (div_last) begin
          rx_shift = 1'b1;
          sck_nxt  = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = HOLD;
          end else begin
            tx_shift  = 1'b1;
            mosi_nxt  = tx_sr[FRAME_BITS-2];
            state_nxt = LOW;
          end
        end
      end
      LOW: begin
        if (div_last) begin
          sck_nxt   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HOLD: begin
        if (div_last) begin
          ssel_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
          rx_load   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (div_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_frame_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ssel_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      if (state == IDLE || div_last) div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;

      if (load)          bit_cnt <= '0;
      else if (rx_shift) bit_cnt <= bit_cnt + 1'b1;

      // MSB goes straight to MOSI at acceptance, so the shifter holds the rest.
      if (load)          tx_sr <= bus.tx_frame[FRAME_BITS-2:0];
      else if (tx_shift) tx_sr <= tx_sr << 1;

      if (rx_shift) rx_sr <= {rx_sr[FRAME_BITS-2:0], miso_s};
      if (rx_load)  rx_frame_q <= rx_sr;

      sck_q  <= sck_nxt;
      mosi_q <= mosi_nxt;
      ssel_q <= ssel_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.rx_frame = rx_frame_q;
  assign bus.SCK      = sck_q;
  assign bus.MOSI     = mosi_q;
  assign bus.SSEL     = ssel_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench: 88-bit/div-25 master in loopback or slave-model mode, plus an 8-bit/div-4 loopback master.
module tb_spi_frame_master;

  logic clk50M;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  spi_frame_master_if #(.FRAME_BITS(88)) bus_a ();
  spi_frame_master_if #(.FRAME_BITS(8))  bus_b ();

  spi_frame_master #(.FRAME_BITS(88), .CLK_DIV(25)) dut_a (
    .clk50M (clk50M),
    .rst_n  (rst_n),
    .bus    (bus_a)
  );

  spi_frame_master #(.FRAME_BITS(8), .CLK_DIV(4)) dut_b (
    .clk50M (clk50M),
    .rst_n  (rst_n),
    .bus    (bus_b)
  );

  initial begin
    clk50M = 1'b0;
    forever #10 clk50M = ~clk50M;
  end

  // Slave model: presents bit 87 when selected, advances on each falling SCK.
  logic        slave_mode = 1'b0;
  logic [87:0] slave_pat  = '0;
  logic        slave_bit;
  int          fall_a     = 0;

  always @(posedge bus_a.SSEL or negedge bus_a.SCK) begin
    if (bus_a.SSEL) fall_a <= 0;
    else            fall_a <= fall_a + 1;
  end

  always_comb begin
    slave_bit = 1'b0;
    if (fall_a < 88) slave_bit = slave_pat[7'(87 - fall_a)];
  end

  assign bus_a.MISO = slave_mode ? slave_bit : bus_a.MOSI;
  assign bus_b.MISO = bus_b.MOSI;

  int          rise_a = 0, rise_b = 0, done_a = 0, ssel_low_a = 0, mosi_hi_a = 0, viol_a = 0;
  logic        prev_sck_a = 1'b0, prev_mosi_a = 1'b0;
  logic [87:0] mosi_cap = '0;
  int          run_b = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
  logic        prev_sck_b = 1'b0;

  always @(posedge bus_a.SCK) begin
    rise_a   <= rise_a + 1;
    mosi_cap <= {mosi_cap[86:0], bus_a.MOSI};
  end

  always @(posedge bus_b.SCK) rise_b <= rise_b + 1;

  always @(negedge clk50M) begin
    if (bus_a.done === 1'b1) done_a <= done_a + 1;
    if (bus_a.SSEL === 1'b0) ssel_low_a <= ssel_low_a + 1;
    if (bus_a.MOSI === 1'b1) mosi_hi_a <= mosi_hi_a + 1;
    if (prev_sck_a && bus_a.SCK && (bus_a.MOSI !== prev_mosi_a)) viol_a <= viol_a + 1;
    prev_sck_a  <= bus_a.SCK;
    prev_mosi_a <= bus_a.MOSI;
  end

  // Length of each completed SCK level run while the 8-bit master is selected.
  always @(negedge clk50M) begin
    if (bus_b.SSEL !== 1'b0) begin
      run_b <= 0;
    end else if (bus_b.SCK === prev_sck_b) begin
      run_b <= run_b + 1;
    end else begin
      if (prev_sck_b) begin
        if (run_b < hi_min) hi_min <= run_b;
        if (run_b > hi_max) hi_max <= run_b;
      end else begin
        if (run_b < lo_min) lo_min <= run_b;
        if (run_b > lo_max) lo_max <= run_b;
      end
      run_b <= 1;
    end
    prev_sck_b <= bus_b.SCK;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int cyc, done_cyc, idle_cyc, base_rise, base_done, base_low, base_hi, n;

  // Accept one frame on bus_a and run until busy drops; cycle 1 is the first cycle after acceptance.
  task automatic run_frame_a(input logic [87:0] tx, input bit scramble, input bit poke);
    @(negedge clk50M);
    bus_a.start    = 1'b1;
    bus_a.tx_frame = tx;
    @(posedge clk50M);
    #1;
    bus_a.start = 1'b0;
    cyc      = 1;
    done_cyc = 0;
    chk("ssel_fall", bus_a.SSEL, 1'b0);
    chk("busy_rise", bus_a.busy, 1'b1);
    while (bus_a.busy && cyc < 6000) begin
      @(posedge clk50M);
      #1;
      cyc++;
      if (bus_a.done) done_cyc = cyc;
      if (scramble) bus_a.tx_frame = 88'({$urandom, $urandom, $urandom});
      bus_a.start = poke && (cyc == 100 || cyc == 4000);
    end
    bus_a.start = 1'b0;
    idle_cyc = cyc;
    chk("frame_timeout", cyc < 6000, 1'b1);
  endtask

  initial begin
    rst_n          = 1'b1;
    bus_a.start    = 1'b0;
    bus_a.tx_frame = '0;
    bus_b.start    = 1'b0;
    bus_b.tx_frame = '0;
    #5 rst_n = 1'b0;
    repeat (3) @(posedge clk50M);
    #1;
    chk("rst_ssel", bus_a.SSEL, 1'b1);
    chk("rst_sck", bus_a.SCK, 1'b0);
    chk("rst_mosi", bus_a.MOSI, 1'b0);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_rx", bus_a.rx_frame, 88'h0);
    @(negedge clk50M);
    rst_n = 1'b1;
    repeat (3) @(posedge clk50M);

    // Loopback
    base_rise = rise_a;
    run_frame_a(88'hA5_0102030405060708090A, 1'b0, 1'b0);
    chk("lb_done_cycle", done_cyc, 4426);
    chk("lb_idle_cycle", idle_cyc, 4451);
    chk("lb_rx", bus_a.rx_frame, 88'hA5_0102030405060708090A);
    chk("lb_sck_rises", rise_a - base_rise, 88);
    chk("lb_mosi_vs_sck", viol_a, 0);

    // Slave model, all-zero command
    slave_pat  = 88'h0FFF_FFFF_FFFF_FFFF_FFFF_F0;
    slave_mode = 1'b1;
    base_low   = ssel_low_a;
    base_hi    = mosi_hi_a;
    run_frame_a(88'h0, 1'b0, 1'b0);
    chk("slv_rx", bus_a.rx_frame, 88'h0FFF_FFFF_FFFF_FFFF_FFFF_F0);
    chk("slv_mosi_zero", mosi_hi_a - base_hi, 0);
    chk("slv_ssel_low", ssel_low_a - base_low, 4425);
    slave_mode = 1'b0;

    // Start pulses while busy are dropped; start in first idle cycle is taken
    base_done = done_a;
    base_rise = rise_a;
    run_frame_a(88'h3C_5A5A5A5A5A5A5A5A5A5A, 1'b0, 1'b1);
    chk("busy_one_done", done_a - base_done, 1);
    chk("busy_one_frame", rise_a - base_rise, 88);
    bus_a.start    = 1'b1;
    bus_a.tx_frame = 88'h77;
    @(posedge clk50M);
    #1;
    bus_a.start = 1'b0;
    chk("b2b_busy", bus_a.busy, 1'b1);
    chk("b2b_ssel", bus_a.SSEL, 1'b0);
    n = 0;
    while (bus_a.busy && n < 6000) begin
      @(posedge clk50M);
      #1;
      n++;
    end
    chk("b2b_done", done_a - base_done, 2);
    chk("b2b_rx", bus_a.rx_frame, 88'h77);

    // tx_frame churn after acceptance
    run_frame_a(88'h1, 1'b1, 1'b0);
    chk("stable_mosi", mosi_cap, 88'h1);
    chk("stable_rx", bus_a.rx_frame, 88'h1);

    // Reset at bit 40
    base_done = done_a;
    base_rise = rise_a;
    @(negedge clk50M);
    bus_a.start    = 1'b1;
    bus_a.tx_frame = 88'hFF_EEDDCCBBAA99887766;
    @(posedge clk50M);
    #1;
    bus_a.start = 1'b0;
    n = 0;
    while ((rise_a - base_rise) < 40 && n < 5000) begin
      @(negedge clk50M);
      n++;
    end
    chk("rst_mid_reached", rise_a - base_rise, 40);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ssel", bus_a.SSEL, 1'b1);
    chk("rst_mid_sck", bus_a.SCK, 1'b0);
    chk("rst_mid_busy", bus_a.busy, 1'b0);
    chk("rst_mid_rx", bus_a.rx_frame, 88'h0);
    repeat (2) @(posedge clk50M);
    @(negedge clk50M);
    rst_n = 1'b1;
    repeat (5000) @(posedge clk50M);
    #1;
    chk("rst_mid_no_done", done_a - base_done, 0);
    chk("rst_mid_idle", bus_a.busy, 1'b0);

    // Minimum divider on the 8-bit master
    base_rise = rise_b;
    @(negedge clk50M);
    bus_b.start    = 1'b1;
    bus_b.tx_frame = 8'h81;
    @(posedge clk50M);
    #1;
    bus_b.start = 1'b0;
    cyc = 1;
    while (!bus_b.done && cyc < 500) begin
      @(posedge clk50M);
      #1;
      cyc++;
    end
    chk("min_done_cycle", cyc, 69);
    chk("min_rx", bus_b.rx_frame, 8'h81);
    chk("min_sck_rises", rise_b - base_rise, 8);
    chk("min_hi_min", hi_min, 4);
    chk("min_hi_max", hi_max, 4);
    chk("min_lo_min", lo_min, 4);
    chk("min_lo_max", lo_max, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
